// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between CORE_COUNT cores and one external port.
// One grant per cycle, two-stage pipeline towards a RAM with one cycle of read latency.
module dmem_arbiter #(
  parameter int CORE_COUNT = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int EXT_BURST  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CORE_COUNT-1:0]            core_req,
  input  logic [CORE_COUNT-1:0]            core_we,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr,
  input  logic [CORE_COUNT*DATA_WIDTH-1:0] core_wdata,
  output logic [CORE_COUNT-1:0]            core_gnt,
  output logic [CORE_COUNT-1:0]            core_rvalid,
  input  logic                             ext_req,
  input  logic                             ext_we,
  input  logic [ADDR_WIDTH-1:0]            ext_addr,
  input  logic [DATA_WIDTH-1:0]            ext_wdata,
  output logic                             ext_gnt,
  output logic                             ext_rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_wrEn,
  output logic [DATA_WIDTH-1:0]            mem_dataIn,
  input  logic [DATA_WIDTH-1:0]            mem_dataOut,
  output logic                             busy
);

  localparam int PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int ID_W  = $clog2(CORE_COUNT + 1);
  localparam int CNT_W = $clog2(EXT_BURST + 1);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      ext_cnt_q, ext_cnt_d;
  logic [PTR_W-1:0]      core_sel_s;
  logic                  core_found_s;
  logic                  any_core_s;
  logic                  core_win_s;
  logic                  ext_win_s;
  logic [ADDR_WIDTH-1:0] win_addr_s;
  logic [DATA_WIDTH-1:0] win_wdata_s;
  logic                  win_we_s;
  logic [ID_W-1:0]       win_id_s;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_wren_q;
  logic [DATA_WIDTH-1:0] mem_din_q;
  logic                  s1_valid_q;
  logic                  s1_read_q;
  logic [ID_W-1:0]       s1_id_q;
  logic [CORE_COUNT-1:0] core_rvalid_q, core_rvalid_d;
  logic                  ext_rvalid_q, ext_rvalid_d;
  logic                  busy_q, busy_d;

  // Round-robin search: first requesting core at rr_ptr, rr_ptr+1, ... modulo CORE_COUNT
  always_comb begin
    core_found_s = 1'b0;
    core_sel_s   = '0;
    for (int j = 0; j < CORE_COUNT; j++) begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        if (!core_found_s && core_req[i] && (((int'(rr_ptr_q) + j) % CORE_COUNT) == i)) begin
          core_found_s = 1'b1;
          core_sel_s   = PTR_W'(i);
        end else begin
          core_found_s = core_found_s;
        end
      end
    end
  end

  assign any_core_s = |core_req;
  // The external port wins unless it has used up its burst while a core waits.
  assign core_win_s = !rst && core_found_s
                      && (!ext_req || (ext_cnt_q == CNT_W'(EXT_BURST)));
  assign ext_win_s  = !rst && ext_req && !core_win_s;
  assign ext_gnt    = ext_win_s;

  // Grant decode and winner mux
  always_comb begin
    core_gnt    = '0;
    win_addr_s  = ext_addr;
    win_wdata_s = ext_wdata;
    win_we_s    = ext_we;
    win_id_s    = ID_W'(CORE_COUNT);
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (core_win_s && (core_sel_s == PTR_W'(i))) begin
        core_gnt[i] = 1'b1;
        win_addr_s  = core_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        win_wdata_s = core_wdata[DATA_WIDTH*i +: DATA_WIDTH];
        win_we_s    = core_we[i];
        win_id_s    = ID_W'(i);
      end else begin
        core_gnt[i] = 1'b0;
      end
    end
  end

  // Next state of the round-robin pointer and the starvation counter
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    ext_cnt_d = ext_cnt_q;
    if (core_win_s) begin
      rr_ptr_d  = (core_sel_s == PTR_W'(CORE_COUNT - 1)) ? '0 : core_sel_s + PTR_W'(1);
      ext_cnt_d = '0;
    end else if (!any_core_s) begin
      ext_cnt_d = '0;
    end else if (ext_win_s) begin
      ext_cnt_d = ext_cnt_q + CNT_W'(1);
    end else begin
      ext_cnt_d = ext_cnt_q;
    end
  end

  // Stage-2 read-valid decode from the stage-1 tag
  always_comb begin
    core_rvalid_d = '0;
    ext_rvalid_d  = s1_valid_q && s1_read_q && (s1_id_q == ID_W'(CORE_COUNT));
    busy_d        = core_win_s || ext_win_s || s1_valid_q;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (s1_valid_q && s1_read_q && (s1_id_q == ID_W'(i))) begin
        core_rvalid_d[i] = 1'b1;
      end else begin
        core_rvalid_d[i] = 1'b0;
      end
    end
  end

  // Arbitration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      ext_cnt_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      ext_cnt_q <= ext_cnt_d;
    end
  end

  // Pipeline: stage 1 drives the memory, stage 2 flags the returning read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q    <= '0;
      mem_wren_q    <= 1'b0;
      mem_din_q     <= '0;
      s1_valid_q    <= 1'b0;
      s1_read_q     <= 1'b0;
      s1_id_q       <= '0;
      core_rvalid_q <= '0;
      ext_rvalid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if (core_win_s || ext_win_s) begin
        mem_addr_q <= win_addr_s;
        mem_din_q  <= win_wdata_s;
        mem_wren_q <= win_we_s;
        s1_valid_q <= 1'b1;
        s1_read_q  <= !win_we_s;
        s1_id_q    <= win_id_s;
      end else begin
        mem_wren_q <= 1'b0;
        s1_valid_q <= 1'b0;
        s1_read_q  <= 1'b0;
      end
      core_rvalid_q <= core_rvalid_d;
      ext_rvalid_q  <= ext_rvalid_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wrEn    = mem_wren_q;
  assign mem_dataIn  = mem_din_q;
  assign core_rvalid = core_rvalid_q;
  assign ext_rvalid  = ext_rvalid_q;
  assign busy        = busy_q;
  assign rdata       = mem_dataOut;

endmodule
